// File: rtl/adc_audio_conditioner.sv
// ADC sample conditioner: rising-edge capture, offset-binary centring, DC-blocking IIR,
// power-of-two gain with 16-bit saturation, and a first-word-fall-through output FIFO.
module adc_audio_conditioner #(
    parameter int DEPTH      = 8,
    parameter int DC_SHIFT   = 10,
    parameter int GAIN_SHIFT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [11:0]              adc_data,
    input  logic                     adc_valid,
    input  logic                     dc_enable,
    input  logic                     rd_strobe,
    output logic [15:0]              audio_out,
    output logic                     audio_valid,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = AW + 1;
    localparam int ACC_W = 13 + DC_SHIFT;

    logic                    r_adc_valid_d;
    logic                    r_v0, r_v1, r_v2;
    logic [11:0]             r_s0_data;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [13:0]      r_hp;
    logic [15:0]             r_scaled;
    logic [15:0]             r_mem [DEPTH];
    logic [AW-1:0]           r_wptr, r_rptr;
    logic [FW-1:0]           r_fill;
    logic                    r_overflow;

    logic                    w_new;
    logic signed [13:0]      w_centered, w_dc, w_hp;
    logic signed [19:0]      w_hp_ext, w_scaled;
    logic [15:0]             w_sat;
    logic                    w_full, w_pop, w_push, w_drop;

    assign w_new      = adc_valid & ~r_adc_valid_d;
    assign w_centered = {{3{~r_s0_data[11]}}, r_s0_data[10:0]};
    assign w_dc       = 14'(r_acc >>> DC_SHIFT);
    assign w_hp       = dc_enable ? (w_centered - w_dc) : w_centered;
    assign w_hp_ext   = {{6{r_hp[13]}}, r_hp};
    assign w_scaled   = w_hp_ext <<< GAIN_SHIFT;

    always_comb begin
        w_sat = w_scaled[15:0];
        if (w_scaled > 20'sd32767)
            w_sat = 16'h7FFF;
        else if (w_scaled < -20'sd32768)
            w_sat = 16'h8000;
    end

    // Pop handshake: an entry leaves on any cycle where rd_strobe=1 and audio_valid=1;
    // a pop frees the slot in the same cycle, so a write to a full FIFO may proceed.
    assign w_full   = (r_fill == FW'(DEPTH));
    assign w_pop    = rd_strobe & (r_fill != '0);
    assign w_push   = r_v2 & (~w_full | w_pop);
    assign w_drop   = r_v2 & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adc_valid_d <= 1'b1;
            r_v0          <= 1'b0;
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_acc         <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_fill        <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_adc_valid_d <= adc_valid;
            r_v0          <= w_new;
            r_v1          <= r_v0;
            r_v2          <= r_v1;
            if (r_v0 && dc_enable)
                r_acc <= r_acc + {{(ACC_W-14){w_hp[13]}}, w_hp};
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Datapath and storage carry no reset; the valid bits and fill qualify them.
    always_ff @(posedge clk) begin
        if (w_new)
            r_s0_data <= adc_data;
        if (r_v0)
            r_hp <= w_hp;
        if (r_v1)
            r_scaled <= w_sat;
        if (w_push)
            r_mem[r_wptr] <= r_scaled;
    end

    assign audio_valid = (r_fill != '0);
    assign audio_out   = audio_valid ? r_mem[r_rptr] : 16'h0000;
    assign fill        = r_fill;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_adc_audio_conditioner.sv
// Scoreboard bench for adc_audio_conditioner: three instances cover the gain and DC settings
// under test; stimulus pushes expected samples, a monitor checks each popped output.
module tb_adc_audio_conditioner;

    logic        clk;
    logic        reset;
    logic        dc_enable;
    logic [11:0] adc_data    [3];
    logic        adc_valid   [3];
    logic        rd          [3];
    logic        man_rd      [3];
    logic        drain       [3];
    logic [15:0] audio_out   [3];
    logic        audio_valid [3];
    logic [3:0]  fill        [3];
    logic        overflow    [3];

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];

    int n_checks = 0;
    int n_errors = 0;
    int last_out0 = 0;
    int mono_prev = 0;
    bit mono_mode = 1'b0;

    adc_audio_conditioner #(.DEPTH(8), .DC_SHIFT(4), .GAIN_SHIFT(2)) u_a (
        .clk(clk), .reset(reset), .adc_data(adc_data[0]), .adc_valid(adc_valid[0]),
        .dc_enable(dc_enable), .rd_strobe(rd[0]), .audio_out(audio_out[0]),
        .audio_valid(audio_valid[0]), .fill(fill[0]), .overflow(overflow[0]));

    adc_audio_conditioner #(.DEPTH(8), .DC_SHIFT(4), .GAIN_SHIFT(5)) u_b (
        .clk(clk), .reset(reset), .adc_data(adc_data[1]), .adc_valid(adc_valid[1]),
        .dc_enable(dc_enable), .rd_strobe(rd[1]), .audio_out(audio_out[1]),
        .audio_valid(audio_valid[1]), .fill(fill[1]), .overflow(overflow[1]));

    adc_audio_conditioner #(.DEPTH(8), .DC_SHIFT(4), .GAIN_SHIFT(0)) u_c (
        .clk(clk), .reset(reset), .adc_data(adc_data[2]), .adc_valid(adc_valid[2]),
        .dc_enable(dc_enable), .rd_strobe(rd[2]), .audio_out(audio_out[2]),
        .audio_valid(audio_valid[2]), .fill(fill[2]), .overflow(overflow[2]));

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [15:0] v);
        case (k)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic pop_check(input int k);
        logic [15:0] e;
        bit          have;
        have = 1'b1;
        e    = 16'h0;
        case (k)
            0:       if (exp_q0.size() == 0) have = 1'b0; else e = exp_q0.pop_front();
            1:       if (exp_q1.size() == 0) have = 1'b0; else e = exp_q1.pop_front();
            default: if (exp_q2.size() == 0) have = 1'b0; else e = exp_q2.pop_front();
        endcase
        if (!have) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pop%0d: got %0d expected no output", k,
                     int'($signed(audio_out[k])));
        end else begin
            check($sformatf("pop%0d", k), int'($signed(audio_out[k])), int'($signed(e)));
        end
    endtask

    // rd_strobe driver: auto-drain or manual, updated just after each rising edge
    initial begin
        for (int k = 0; k < 3; k++) rd[k] = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 3; k++) rd[k] = drain[k] ? audio_valid[k] : man_rd[k];
        end
    end

    // monitor: every accepted pop is compared against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rd[k] && audio_valid[k] && !reset) begin
                    pop_check(k);
                    if (k == 0) begin
                        last_out0 = int'($signed(audio_out[0]));
                        if (mono_mode) begin
                            check("dc_monotonic", int'(last_out0 <= mono_prev), 1);
                            mono_prev = last_out0;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [11:0] d);
        @(posedge clk);
        #1;
        adc_data[k]  = d;
        adc_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        adc_valid[k] = 1'b0;
    endtask

    task automatic wait_drain(input int k, input string name);
        int t;
        t = 0;
        while ((qsize(k) != 0 || audio_valid[k]) && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (t >= 600) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, qsize(k));
        end
    endtask

    initial begin
        int acc_m;
        int hp_m;
        int e;
        reset     = 1'b1;
        dc_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            adc_valid[k] = 1'b1;
            adc_data[k]  = 12'h000;
            man_rd[k]    = 1'b0;
            drain[k]     = 1'b0;
        end

        // reset with adc_valid already high
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_audio_out%0d", k), int'(audio_out[k]), 0);
            check($sformatf("rst_valid%0d", k), int'(audio_valid[k]), 0);
            check($sformatf("rst_fill%0d", k), int'(fill[k]), 0);
            check($sformatf("rst_overflow%0d", k), int'(overflow[k]), 0);
        end
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("held_high_no_sample%0d", k), int'(audio_valid[k]), 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) adc_valid[k] = 1'b0;

        // centring and 3-cycle latency
        @(posedge clk);
        #1;
        adc_data[0]  = 12'hFFF;
        adc_valid[0] = 1'b1;
        @(posedge clk);
        #1 adc_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("lat_before_T3", int'(audio_valid[0]), 0);
        @(negedge clk);
        check("lat_valid_T3", int'(audio_valid[0]), 1);
        check("lat_fill_T3", int'(fill[0]), 1);
        push_exp(0, 16'd8188);
        drain[0] = 1'b1;
        wait_drain(0, "centre_fff");
        push_exp(0, 16'd0);
        send(0, 12'h800);
        wait_drain(0, "centre_800");

        // saturation at gain x32
        drain[1] = 1'b1;
        push_exp(1, 16'h7FFF);
        send(1, 12'hFFF);
        push_exp(1, 16'h8000);
        send(1, 12'h000);
        push_exp(1, 16'd32);
        send(1, 12'h801);
        wait_drain(1, "saturation");

        // DC removal on a constant +1024 input
        @(negedge clk);
        dc_enable = 1'b1;
        acc_m     = 0;
        mono_prev = 32767;
        mono_mode = 1'b1;
        for (int n = 0; n < 256; n++) begin
            hp_m  = 1024 - (acc_m >>> 4);
            acc_m = acc_m + hp_m;
            if (n == 0)      e = 4096;
            else if (n == 1) e = 3840;
            else             e = hp_m * 4;
            push_exp(0, 16'(e));
            send(0, 12'hC00);
        end
        wait_drain(0, "dc_series");
        mono_mode = 1'b0;
        check("dc_settled_le4", int'(last_out0 <= 4 && last_out0 >= -4), 1);

        // FIFO full and overflow
        @(negedge clk);
        dc_enable = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) push_exp(2, 16'(i));
            send(2, 12'(12'h800 + i));
        end
        repeat (5) @(negedge clk);
        check("full_fill", int'(fill[2]), 8);
        check("full_overflow", int'(overflow[2]), 1);
        drain[2] = 1'b1;
        wait_drain(2, "full_drain");
        check("drained_valid", int'(audio_valid[2]), 0);
        check("overflow_sticky", int'(overflow[2]), 1);
        drain[2] = 1'b0;

        // mid-operation reset discards the in-flight sample and clears acc
        @(negedge clk);
        dc_enable = 1'b1;
        @(posedge clk);
        #1;
        adc_data[0]  = 12'hC00;
        adc_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        adc_valid[0] = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_write", int'(audio_valid[0]), 0);
        check("midrst_fill", int'(fill[0]), 0);
        check("midrst_ovf_cleared", int'(overflow[2]), 0);
        push_exp(0, 16'd4096);
        send(0, 12'hC00);
        wait_drain(0, "midrst_after");

        // simultaneous read and write while full
        @(negedge clk);
        dc_enable = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push_exp(2, 16'(i));
            send(2, 12'(12'h800 + i));
        end
        repeat (5) @(negedge clk);
        check("rw_pre_fill", int'(fill[2]), 8);
        check("rw_pre_ovf", int'(overflow[2]), 0);
        push_exp(2, 16'd9);
        @(posedge clk);
        #1;
        adc_data[2]  = 12'h809;
        adc_valid[2] = 1'b1;
        @(posedge clk);
        #1 adc_valid[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 man_rd[2] = 1'b1;
        @(posedge clk);
        #1 man_rd[2] = 1'b0;
        @(negedge clk);
        check("rw_fill_kept", int'(fill[2]), 8);
        check("rw_no_overflow", int'(overflow[2]), 0);
        drain[2] = 1'b1;
        wait_drain(2, "rw_drain");
        check("rw_final_ovf", int'(overflow[2]), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
